// File: rtl/im_prefetch.sv
// Instruction prefetch queue between a variable-latency instruction memory and the F stage.
// Optional same-cycle response bypass to F when IM_PREFETCH_BYPASS_EN is defined.
module im_prefetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        f_valid,
  output logic [31:0] f_pc,
  output logic [31:0] f_instr,
  input  logic        f_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_X = (CW+1)'(DEPTH);

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  function automatic logic [31:0] next_word(input logic [31:0] a);
    return a + 32'd4;
  endfunction

  logic          run;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [31:0]   resp_pc;
  logic [31:0]   hold_pc;
  logic [31:0]   hold_instr;
  logic [31:0]   pc_q    [DEPTH];
  logic [31:0]   instr_q [DEPTH];

  logic [CW:0]   occupancy;
  logic          issue;
  logic          rsp;
  logic          rsp_keep;
  logic          q_valid;
  logic          byp_hit;
  logic          byp_take;
  logic          pop;
  logic          push;

  // Request / response qualification
  always_comb begin
    occupancy = {1'b0, count} + {1'b0, outstanding};
    mem_req   = run && (occupancy < DEPTH_X);
    issue     = mem_req && mem_gnt;
    // A response with nothing outstanding is a protocol error and is ignored.
    rsp       = mem_rvalid && (outstanding != '0);
    rsp_keep  = rsp && (discard == '0);
    q_valid   = (count != '0);
  end

`ifdef IM_PREFETCH_BYPASS_EN
  always_comb begin
    byp_hit  = !q_valid && rsp_keep;
    byp_take = byp_hit && f_ready && !redirect;
  end
`else
  always_comb begin
    byp_hit  = 1'b0;
    byp_take = 1'b0;
  end
`endif

  // Head presentation to F
  always_comb begin
    f_valid = q_valid || byp_hit;
    if (q_valid) begin
      f_pc    = pc_q[rd_ptr];
      f_instr = instr_q[rd_ptr];
    end else if (byp_hit) begin
      f_pc    = resp_pc;
      f_instr = mem_rdata;
    end else begin
      f_pc    = hold_pc;
      f_instr = hold_instr;
    end
    pop  = q_valid && f_ready && !redirect;
    push = rsp_keep && !redirect && !byp_take;
  end

  // Control state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run         <= 1'b0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      resp_pc     <= word_align(RESET_PC);
      mem_addr    <= word_align(RESET_PC);
      hold_pc     <= '0;
      hold_instr  <= '0;
    end else begin
      run <= 1'b1;

      case ({issue, rsp})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase

      if (f_valid) begin
        hold_pc    <= f_pc;
        hold_instr <= f_instr;
      end

      if (push) wr_ptr <= wr_ptr + AW'(1);

      if (redirect) begin
        count    <= '0;
        rd_ptr   <= wr_ptr;
        // Every word still in flight after this edge belongs to the old stream.
        discard  <= outstanding + CW'(issue) - CW'(rsp);
        resp_pc  <= word_align(redirect_pc);
        mem_addr <= word_align(redirect_pc);
      end else begin
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        if (rsp && (discard != '0)) discard <= discard - CW'(1);
        if (rsp_keep) resp_pc <= next_word(resp_pc);
        if (issue) mem_addr <= next_word(mem_addr);
      end
    end
  end

  // Queue storage
  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[wr_ptr]    <= resp_pc;
      instr_q[wr_ptr] <= mem_rdata;
    end
  end

  rvalid_without_request: assert property (@(posedge clk) disable iff (!rst)
    !(mem_rvalid && (outstanding == '0)));

endmodule

// File: tb/tb_im_prefetch.sv
// Directed self-checking bench for im_prefetch with a one-cycle in-order memory model.
module tb_im_prefetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        f_valid;
  logic [31:0] f_pc;
  logic [31:0] f_instr;
  logic        f_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  int          checks = 0;
  int          errors = 0;
  int          grants = 0;
  bit          resp_en;
  logic [31:0] pend[$];

  im_prefetch #(.DEPTH(4), .RESET_PC(32'h0000_3000)) dut (
    .clk(clk), .rst(rst),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .f_valid(f_valid), .f_pc(f_pc), .f_instr(f_instr), .f_ready(f_ready),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // One clock: memory model records grants and answers in order one cycle later.
  task automatic tick();
    bit          iss;
    bit          rsp;
    logic [31:0] a;
    iss = rst && mem_req && mem_gnt;
    rsp = mem_rvalid;
    a   = mem_addr;
    @(posedge clk);
    #1;
    if (!rst) begin
      pend.delete();
      mem_rvalid = 1'b0;
    end else begin
      if (rsp && pend.size() > 0) void'(pend.pop_front());
      if (iss) begin
        pend.push_back(a);
        grants++;
      end
      if (resp_en && pend.size() > 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = word_of(pend[0]);
      end else begin
        mem_rvalid = 1'b0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b0;
    mem_rvalid = 1'b0;
    redirect   = 1'b0;
    pend.delete();
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", mem_req); end
    checks++; if (mem_addr !== 32'h3000) begin errors++; $display("FAIL reset_addr: got %h expected 00003000", mem_addr); end
    checks++; if (f_valid !== 1'b0) begin errors++; $display("FAIL reset_fvalid: got %b expected 0", f_valid); end
    checks++; if (f_pc !== 32'h0 || f_instr !== 32'h0) begin errors++; $display("FAIL reset_fdata: got pc %h instr %h expected 0/0", f_pc, f_instr); end
    rst = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL release_req: got %b expected 0", mem_req); end
    tick();
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL first_req: got %b expected 1", mem_req); end
  endtask

  task automatic test_stream();
    logic [31:0] exp;
    do_reset();
    mem_gnt = 1'b1; resp_en = 1'b1; f_ready = 1'b1;
    checks++; if (mem_addr !== 32'h3000) begin errors++; $display("FAIL stream_addr0: got %h expected 00003000", mem_addr); end
    for (int i = 1; i <= 6; i++) begin
      tick();
      exp = 32'h3000 + 32'(4 * i);
      checks++; if (mem_addr !== exp) begin errors++; $display("FAIL stream_addr: got %h expected %h", mem_addr, exp); end
      if (i >= 2) begin
        exp = 32'h3000 + 32'(4 * (i - 2));
        checks++;
        if (f_valid !== 1'b1 || f_pc !== exp || f_instr !== word_of(exp)) begin
          errors++;
          $display("FAIL stream_head: got v%b pc %h instr %h expected v1 pc %h instr %h", f_valid, f_pc, f_instr, exp, word_of(exp));
        end
      end
    end
  endtask

  task automatic test_full();
    logic [31:0] exp;
    do_reset();
    mem_gnt = 1'b1; resp_en = 1'b1; f_ready = 1'b0;
    grants = 0;
    for (int i = 0; i < 10; i++) tick();
    checks++; if (grants != 4) begin errors++; $display("FAIL full_grants: got %0d expected 4", grants); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL full_req: got %b expected 0", mem_req); end
    f_ready = 1'b1;
    #1;
    for (int k = 0; k <= 4; k++) begin
      exp = 32'h3000 + 32'(4 * k);
      checks++; if (f_valid !== 1'b1 || f_pc !== exp) begin errors++; $display("FAIL full_drain: got v%b pc %h expected v1 pc %h", f_valid, f_pc, exp); end
      if (k == 1) begin
        checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL full_rereq: got %b expected 1", mem_req); end
      end
      tick();
    end
  endtask

  task automatic test_redirect_drop();
    bit found;
    do_reset();
    f_ready = 1'b0; resp_en = 1'b0; mem_gnt = 1'b1;
    tick(); tick();
    mem_gnt = 1'b0; resp_en = 1'b1;
    tick(); tick(); tick();
    mem_gnt = 1'b1; resp_en = 1'b0;
    tick(); tick();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL drop_req: got %b expected 0", mem_req); end
    mem_gnt = 1'b0; resp_en = 1'b1;
    redirect = 1'b1; redirect_pc = 32'h3100;
    tick();
    redirect = 1'b0; mem_gnt = 1'b1;
    #1;
    checks++; if (mem_addr !== 32'h3100) begin errors++; $display("FAIL drop_addr: got %h expected 00003100", mem_addr); end
    checks++; if (f_valid !== 1'b0 || f_pc !== 32'h3000) begin errors++; $display("FAIL drop_flush: got v%b pc %h expected v0 pc 00003000", f_valid, f_pc); end
    f_ready = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      tick();
      if (f_valid) found = 1'b1;
    end
    checks++;
    if (!found || f_pc !== 32'h3100 || f_instr !== word_of(32'h3100)) begin
      errors++;
      $display("FAIL drop_first: got found %b pc %h instr %h expected pc 00003100 instr %h", found, f_pc, f_instr, word_of(32'h3100));
    end
  endtask

  task automatic test_redirect_pop();
    bit found;
    do_reset();
    mem_gnt = 1'b1; resp_en = 1'b1; f_ready = 1'b1;
    tick(); tick(); tick();
    checks++; if (f_valid !== 1'b1 || f_pc !== 32'h3004) begin errors++; $display("FAIL rpop_head: got v%b pc %h expected v1 pc 00003004", f_valid, f_pc); end
    redirect = 1'b1; redirect_pc = 32'h3200;
    tick();
    redirect = 1'b0;
    #1;
    checks++; if (f_valid !== 1'b0) begin errors++; $display("FAIL rpop_flush: got %b expected 0", f_valid); end
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      tick();
      if (f_valid) found = 1'b1;
    end
    checks++; if (!found || f_pc !== 32'h3200) begin errors++; $display("FAIL rpop_first: got found %b pc %h expected pc 00003200", found, f_pc); end
  endtask

  task automatic test_wrap();
    bit found;
    do_reset();
    mem_gnt = 1'b1; resp_en = 1'b1; f_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect = 1'b0;
    #1;
    checks++; if (mem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr0: got %h expected fffffffc", mem_addr); end
    tick();
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr1: got %h expected 00000000", mem_addr); end
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      tick();
      if (f_valid) found = 1'b1;
    end
    checks++; if (!found || f_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc0: got found %b pc %h expected fffffffc", found, f_pc); end
    tick();
    checks++; if (f_valid !== 1'b1 || f_pc !== 32'h0) begin errors++; $display("FAIL wrap_pc1: got v%b pc %h expected v1 pc 00000000", f_valid, f_pc); end
  endtask

  task automatic test_back_to_back();
    bit found;
    do_reset();
    mem_gnt = 1'b1; resp_en = 1'b1; f_ready = 1'b1;
    tick(); tick();
    checks++; if (f_valid !== 1'b1 || f_pc !== 32'h3000) begin errors++; $display("FAIL b2b_head: got v%b pc %h expected v1 pc 00003000", f_valid, f_pc); end
    redirect = 1'b1; redirect_pc = 32'h4000;
    tick();
    redirect_pc = 32'h5000;
    tick();
    redirect = 1'b0;
    #1;
    checks++; if (mem_addr !== 32'h5000 || f_valid !== 1'b0) begin errors++; $display("FAIL b2b_addr: got addr %h v%b expected addr 00005000 v0", mem_addr, f_valid); end
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      tick();
      if (f_valid) found = 1'b1;
    end
    checks++; if (!found || f_pc !== 32'h5000) begin errors++; $display("FAIL b2b_first: got found %b pc %h expected pc 00005000", found, f_pc); end
  endtask

  task automatic test_bypass();
    do_reset();
    mem_gnt = 1'b1; resp_en = 1'b0; f_ready = 1'b1;
    tick();
    mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h2408_0001;
    #1;
`ifdef IM_PREFETCH_BYPASS_EN
    checks++; if (f_valid !== 1'b1 || f_instr !== 32'h2408_0001 || f_pc !== 32'h3000) begin errors++; $display("FAIL bypass_same: got v%b pc %h instr %h expected v1 pc 00003000 instr 24080001", f_valid, f_pc, f_instr); end
    tick();
    checks++; if (f_valid !== 1'b0 || f_instr !== 32'h2408_0001) begin errors++; $display("FAIL bypass_after: got v%b instr %h expected v0 instr 24080001", f_valid, f_instr); end
`else
    checks++; if (f_valid !== 1'b0) begin errors++; $display("FAIL bypass_same: got v%b expected v0", f_valid); end
    tick();
    checks++; if (f_valid !== 1'b1 || f_instr !== 32'h2408_0001 || f_pc !== 32'h3000) begin errors++; $display("FAIL bypass_after: got v%b pc %h instr %h expected v1 pc 00003000 instr 24080001", f_valid, f_pc, f_instr); end
`endif
  endtask

  task automatic test_mid_reset();
    do_reset();
    mem_gnt = 1'b1; resp_en = 1'b1; f_ready = 1'b1;
    tick(); tick(); tick(); tick();
    rst = 1'b0;
    #1;
    checks++; if (mem_req !== 1'b0 || mem_addr !== 32'h3000) begin errors++; $display("FAIL midrst_mem: got req %b addr %h expected req 0 addr 00003000", mem_req, mem_addr); end
    checks++; if (f_valid !== 1'b0 || f_pc !== 32'h0 || f_instr !== 32'h0) begin errors++; $display("FAIL midrst_f: got v%b pc %h instr %h expected v0 0/0", f_valid, f_pc, f_instr); end
    do_reset();
  endtask

  initial begin
    rst = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    f_ready = 1'b0; redirect = 1'b0; redirect_pc = '0; resp_en = 1'b0;
    test_reset();
    test_stream();
    test_full();
    test_redirect_drop();
    test_redirect_pop();
    test_wrap();
    test_back_to_back();
    test_bypass();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
